note_block_scroller: RTL and testbench
======================================

// Module: note_block_scroller
// PURPOSE
//  Game-side writer of the 16-row x 4-column block frame consumed by the LED matrix driver.
//  Accepts note rows from the chart sequencer through a valid/ready handshake and buffers them in a small FIFO.
//  Scrolls the frame down one row per tempo step, then judges player key presses against the bottom hit window.
//  Sits between chart/tempo logic and the display and score logic.
// PARAMETERS
//  ROWS        16  frame height; row 0 = top (spawn), row ROWS-1 = bottom (hit line)
//  COLS        4   game columns; bit c of a row = column c
//  FIFO_DEPTH  4   note-row FIFO entries (power of 2)
//  HIT_WIN     2   hit window = bottom HIT_WIN rows (ROWS-HIT_WIN .. ROWS-1)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous, active-low reset
//  game_en      in   1          level; 1 = run, 0 = stop spawning and flush
//  step_tick    in   1          1-cycle tempo pulse; one scroll step per pulse
//  note_valid   in   1          note_row valid
//  note_row     in   COLS       column mask for the next spawned row
//  note_ready   out  1          FIFO can accept (not full and state != FLUSH)
//  key_hit      in   COLS       1-cycle debounced press pulse per column
//  block_flat   out  ROWS*COLS  frame; row r = [r*COLS +: COLS]
//  hit_pulse    out  COLS       1-cycle: press matched a block in the window
//  miss_pulse   out  COLS       1-cycle: block left row ROWS-1 unhit
//  empty_press  out  COLS       1-cycle: press with no block in the window for that column
//  frame_upd    out  1          1-cycle: block_flat changed this cycle
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, frame cleared, FIFO empty, state IDLE. Reset mid-game drops the frame and FIFO at once.
//  All outputs are registered; each pulse appears the cycle after the causing input.
//  FIFO: push when note_valid & note_ready. A push to a full FIFO cannot occur (ready low).
//    Push and pop in the same cycle are both allowed when non-empty.
//  FSM:
//    IDLE->RUN on game_en.
//    RUN->FLUSH when game_en=0.
//    FLUSH->IDLE when frame all-zero and FIFO empty.
//    FLUSH->RUN if game_en returns.
//  step_tick in RUN: shift rows down by one. Row 0 loads the FIFO head (pop) if the FIFO is non-empty, else 0.
//  step_tick in FLUSH: shift rows down with row 0 = 0. The FIFO is discarded on FLUSH entry.
//  step_tick in IDLE is ignored.
//  Miss: on shift, each set bit of old row ROWS-1 -> miss_pulse[c].
//  Hit (RUN/FLUSH): for each c with key_hit[c], take the highest-index row in the window with bit c set.
//    That bit is cleared and hit_pulse[c] asserts.
//    If the window has no such bit, empty_press[c] asserts instead.
//    Columns are judged independently and can fire in the same cycle.
//  key_hit in IDLE is ignored: no pulses.
//  Same-cycle step_tick and key_hit: judge the pre-shift frame first, then shift.
//    A bit hit in row ROWS-1 is cleared and does not raise miss.
//    A bit hit in a row below ROWS-1 moves down already cleared.
//  frame_upd asserts whenever block_flat changes (shift or hit clear).
// STRUCTURE
//  Shared package: constants ROWS, COLS, and the FSM state encoding {IDLE, RUN, FLUSH}.
//  Sub-module note_row_fifo: synchronous FIFO, width COLS, depth FIFO_DEPTH, with push/pop/full/empty/flush.
//  Frame shift register, judge logic and FSM live in the top module.
// TESTING
//  1. Reset, game_en=1, push 4'b0001, then 16 step_ticks.
//     -> bit 0 walks rows 0..15; tick 17 gives miss_pulse=4'b0001; final state is RUN with an all-zero frame.
//  2. Push 4 rows with no tick -> note_ready=0 after the 4th.
//     A 5th push held until 1 tick -> accepted the cycle after the pop.
//  3. Block at row 14, col 2; key_hit=4'b0100 -> hit_pulse=4'b0100 next cycle and row 14 is cleared.
//     A repeat press -> empty_press=4'b0100.
//  4. Block at row 15, col 3; key_hit[3] and step_tick in the same cycle.
//     -> hit_pulse[3]=1, miss_pulse=0, frame shifted.
//  5. Blocks in rows 3 and 9 with FIFO holding 2 rows; drop game_en.
//     -> FLUSH, note_ready=0, FIFO emptied, no new spawns; busy falls after the last miss (13 ticks).
//  6. rst_n low mid-scroll -> block_flat=0 and all pulses 0 immediately; IDLE after release.

Source files
------------

// File: rtl/note_block_scroller_pkg.sv
// ============================================================================
// Module      : note_block_scroller_pkg
// Description : Shared frame geometry and FSM state encoding for the scroller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_block_scroller_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } scroll_state_t;

endpackage

`default_nettype wire

// File: rtl/note_block_scroller_fifo.sv
// ============================================================================
// Module      : note_row_fifo
// Description : Synchronous note-row FIFO with occupancy count and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_row_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == C_DEPTH);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_block_scroller.sv
// ============================================================================
// Module      : note_block_scroller
// Description : Scrolls spawned note rows down the block frame and judges key
//               presses against the bottom hit window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_block_scroller
    import note_block_scroller_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HIT_WIN    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_en,
    input  logic                 step_tick,
    input  logic                 note_valid,
    input  logic [COLS-1:0]      note_row,
    output logic                 note_ready,
    input  logic [COLS-1:0]      key_hit,
    output logic [ROWS*COLS-1:0] block_flat,
    output logic [COLS-1:0]      hit_pulse,
    output logic [COLS-1:0]      miss_pulse,
    output logic [COLS-1:0]      empty_press,
    output logic                 frame_upd,
    output logic                 busy
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

    scroll_state_t                r_state;
    scroll_state_t                w_state_nxt;
    logic [ROWS-1:0][COLS-1:0]    r_frame;
    logic [ROWS-1:0][COLS-1:0]    w_judged;
    logic [ROWS-1:0][COLS-1:0]    w_frame_nxt;
    logic [COLS-1:0]              w_hit;
    logic [COLS-1:0]              w_empty;
    logic [COLS-1:0]              w_miss;
    logic [COLS-1:0]              w_spawn;
    logic [COLS-1:0]              w_fifo_head;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [AW:0]                  w_fifo_count;
    logic [AW:0]                  w_count_nxt;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_flush;
    logic                         w_shift;

    assign block_flat = r_frame;
    assign w_push     = note_valid && note_ready;
    assign w_shift    = step_tick && (r_state != IDLE);
    assign w_pop      = step_tick && (r_state == RUN) && !w_fifo_empty;
    // Queued rows are discarded the moment the game stops.
    assign w_flush    = (r_state == RUN) && !game_en;
    assign w_spawn    = w_pop ? w_fifo_head : '0;

    note_row_fifo #(
        .WIDTH (COLS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (note_row),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Judge on the pre-shift frame so a hit bit never also counts as a miss.
    always_comb begin
        w_judged = r_frame;
        w_hit    = '0;
        w_empty  = '0;
        if (r_state != IDLE) begin
            for (int c = 0; c < COLS; c++) begin
                if (key_hit[c]) begin
                    for (int r = ROWS-1; r >= ROWS-HIT_WIN; r--) begin
                        if (!w_hit[c] && r_frame[r][c]) begin
                            w_judged[r][c] = 1'b0;
                            w_hit[c]       = 1'b1;
                        end
                    end
                    w_empty[c] = !w_hit[c];
                end
            end
        end
    end

    always_comb begin
        w_frame_nxt = w_judged;
        w_miss      = '0;
        if (w_shift) begin
            w_miss      = w_judged[ROWS-1];
            w_frame_nxt = {w_judged[ROWS-2:0], w_spawn};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (game_en) w_state_nxt = RUN;
            RUN:     if (!game_en) w_state_nxt = FLUSH;
            FLUSH: begin
                if (game_en)
                    w_state_nxt = RUN;
                else if ((r_frame == '0) && w_fifo_empty)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (w_flush)
            w_count_nxt = '0;
        else
            w_count_nxt = w_fifo_count + (AW+1)'(w_push && !w_fifo_full)
                                       - (AW+1)'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_frame     <= '0;
            hit_pulse   <= '0;
            miss_pulse  <= '0;
            empty_press <= '0;
            frame_upd   <= 1'b0;
            busy        <= 1'b0;
            note_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            hit_pulse   <= w_hit;
            miss_pulse  <= w_miss;
            empty_press <= w_empty;
            frame_upd   <= (w_frame_nxt != r_frame);
            busy        <= (w_state_nxt != IDLE);
            note_ready  <= (w_state_nxt != FLUSH) && (w_count_nxt != C_DEPTH);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_note_block_scroller.sv
// ============================================================================
// Module      : tb_note_block_scroller
// Description : Directed self-checking bench for note_block_scroller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_block_scroller;

    logic        clk;
    logic        rst_n;
    logic        game_en;
    logic        step_tick;
    logic        note_valid;
    logic [3:0]  note_row;
    logic        note_ready;
    logic [3:0]  key_hit;
    logic [63:0] block_flat;
    logic [3:0]  hit_pulse;
    logic [3:0]  miss_pulse;
    logic [3:0]  empty_press;
    logic        frame_upd;
    logic        busy;

    int n_checks;
    int n_errors;

    note_block_scroller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_en     (game_en),
        .step_tick   (step_tick),
        .note_valid  (note_valid),
        .note_row    (note_row),
        .note_ready  (note_ready),
        .key_hit     (key_hit),
        .block_flat  (block_flat),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .empty_press (empty_press),
        .frame_upd   (frame_upd),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
    endtask

    task automatic push(input logic [3:0] row);
        note_valid = 1'b1;
        note_row   = row;
        cyc();
        note_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        game_en    = 1'b0;
        step_tick  = 1'b0;
        note_valid = 1'b0;
        note_row   = '0;
        key_hit    = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset values
        rst_n      = 1'b0;
        game_en    = 1'b0;
        step_tick  = 1'b0;
        note_valid = 1'b0;
        note_row   = '0;
        key_hit    = '0;
        cyc();
        cyc();
        check("rst_frame", block_flat, 64'h0);
        check("rst_busy",  busy, 1'b0);
        check("rst_ready", note_ready, 1'b0);
        check("rst_pulses", {hit_pulse, miss_pulse, empty_press, frame_upd}, 13'h0);
        rst_n = 1'b1;
        cyc();
        check("idle_ready", note_ready, 1'b1);

        // 1: single note walks the full frame then misses
        game_en = 1'b1;
        cyc();
        check("t1_busy", busy, 1'b1);
        push(4'b0001);
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("t1_walk%0d", i), block_flat, 64'h1 << (i*4));
        end
        check("t1_upd", frame_upd, 1'b1);
        tick();
        check("t1_miss", miss_pulse, 4'b0001);
        check("t1_empty_frame", block_flat, 64'h0);
        cyc();
        check("t1_miss_1cyc", miss_pulse, 4'b0000);
        check("t1_run", busy, 1'b1);

        // 2: FIFO fills, held push accepted the cycle after a pop
        push(4'b0001);
        push(4'b0010);
        push(4'b0100);
        check("t2_ready3", note_ready, 1'b1);
        push(4'b1000);
        check("t2_full", note_ready, 1'b0);
        note_valid = 1'b1;
        note_row   = 4'b1111;
        tick();
        check("t2_ready_after_pop", note_ready, 1'b1);
        check("t2_spawn", block_flat, 64'h1);
        cyc();
        note_valid = 1'b0;
        check("t2_full_again", note_ready, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("t2_order", block_flat, 64'h1248F);

        // 3: hit in window then repeat press on the cleared column
        do_reset();
        game_en = 1'b1;
        cyc();
        push(4'b0100);
        for (int i = 0; i < 15; i++) tick();
        check("t3_row14", block_flat, 64'h4 << 56);
        key_hit = 4'b0100;
        cyc();
        key_hit = '0;
        check("t3_hit", hit_pulse, 4'b0100);
        check("t3_cleared", block_flat, 64'h0);
        check("t3_upd", frame_upd, 1'b1);
        check("t3_no_empty", empty_press, 4'b0000);
        cyc();
        check("t3_hit_1cyc", hit_pulse, 4'b0000);
        key_hit = 4'b0100;
        cyc();
        key_hit = '0;
        check("t3_empty", empty_press, 4'b0100);
        check("t3_no_hit", hit_pulse, 4'b0000);
        check("t3_no_upd", frame_upd, 1'b0);

        // 4: bottom-most block chosen, same-cycle hit and shift
        do_reset();
        game_en = 1'b1;
        cyc();
        push(4'b1000);
        push(4'b1001);
        for (int i = 0; i < 16; i++) tick();
        check("t4_setup", block_flat, (64'h8 << 60) | (64'h9 << 56));
        key_hit   = 4'b1000;
        step_tick = 1'b1;
        cyc();
        key_hit   = '0;
        step_tick = 1'b0;
        check("t4_hit", hit_pulse, 4'b1000);
        check("t4_no_miss", miss_pulse, 4'b0000);
        check("t4_shifted", block_flat, 64'h9 << 60);
        key_hit = 4'b1010;
        cyc();
        key_hit = '0;
        check("t4_hit2", hit_pulse, 4'b1000);
        check("t4_empty2", empty_press, 4'b0010);
        check("t4_frame2", block_flat, 64'h1 << 60);
        tick();
        check("t4_miss", miss_pulse, 4'b0001);

        // 5: flush with blocks at rows 9 and 3 and two queued rows
        do_reset();
        game_en = 1'b1;
        cyc();
        push(4'b0010);
        for (int i = 0; i < 6; i++) tick();
        push(4'b0100);
        for (int i = 0; i < 4; i++) tick();
        push(4'b1111);
        push(4'b1111);
        check("t5_setup", block_flat, (64'h2 << 36) | (64'h4 << 12));
        game_en = 1'b0;
        cyc();
        check("t5_flush_ready", note_ready, 1'b0);
        check("t5_flush_busy", busy, 1'b1);
        tick();
        check("t5_no_spawn", block_flat, (64'h2 << 40) | (64'h4 << 16));
        for (int i = 1; i < 7; i++) tick();
        check("t5_miss_a", miss_pulse, 4'b0010);
        for (int i = 7; i < 13; i++) tick();
        check("t5_miss_b", miss_pulse, 4'b0100);
        check("t5_frame0", block_flat, 64'h0);
        cyc();
        check("t5_idle", busy, 1'b0);
        check("t5_ready", note_ready, 1'b1);
        key_hit = 4'b1111;
        cyc();
        key_hit = '0;
        check("t5_idle_press", {hit_pulse, empty_press}, 8'h00);
        game_en = 1'b1;
        cyc();
        tick();
        check("t5_fifo_dropped", block_flat, 64'h0);

        // 6: asynchronous reset mid-scroll
        push(4'b0001);
        for (int i = 0; i < 3; i++) tick();
        key_hit = 4'b0010;
        cyc();
        key_hit = '0;
        check("t6_pre_empty", empty_press, 4'b0010);
        #2;
        rst_n   = 1'b0;
        game_en = 1'b0;
        #1;
        check("t6_async_frame", block_flat, 64'h0);
        check("t6_async_pulse", empty_press, 4'b0000);
        check("t6_async_busy", busy, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check("t6_idle", busy, 1'b0);
        check("t6_frame_after", block_flat, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
